// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Registered MEM/WB stage with load formatting, writeback mux,
//            register-file write port, forwarding bus and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [REG_ADDR_W-1:0]       in_rd_addr,
    input  logic                        in_rd_write_en,
    input  logic [1:0]                  in_writeback_data_sel,
    input  logic [XLEN-1:0]             in_alu_data_out,
    input  logic [XLEN-1:0]             in_dm_read_data,
    input  logic [XLEN-1:0]             in_writeback_PC,
    input  logic [XLEN-1:0]             in_imm,
    input  logic [2:0]                  in_load_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   in_byte_offset,
    output logic                        rf_write_en,
    output logic [REG_ADDR_W-1:0]       rf_write_addr,
    output logic [XLEN-1:0]             rf_write_data,
    output logic                        fwd_valid,
    output logic [REG_ADDR_W-1:0]       fwd_addr,
    output logic [XLEN-1:0]             fwd_data,
    output logic [RETIRE_CNT_W-1:0]     retire_count
);

    localparam int OFF_W = $clog2(XLEN/8);

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC  = 2'd2;
    localparam logic [1:0] SEL_IMM = 2'd3;

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_lw;
    logic [XLEN-1:0] w_lwu;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wb_data;
    logic            w_capture;
    logic            w_rd_live;

    assign w_byte = in_dm_read_data[{in_byte_offset, 3'b000} +: 8];
    // offset[0] is ignored for halves; misaligned halves trap before this stage
    assign w_half = in_dm_read_data[{in_byte_offset[OFF_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_xlen64
            logic [31:0] w_word;
            assign w_word = in_dm_read_data[{in_byte_offset[OFF_W-1], 5'b00000} +: 32];
            assign w_lw   = {{(XLEN-32){w_word[31]}}, w_word};
            assign w_lwu  = {{(XLEN-32){1'b0}}, w_word};
        end else begin : g_xlen32
            assign w_lw  = in_dm_read_data;
            assign w_lwu = in_dm_read_data;
        end
    endgenerate

    always_comb begin
        w_load_data = in_dm_read_data;
        case (in_load_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            3'b010:  w_load_data = w_lw;
            3'b110:  w_load_data = w_lwu;
            default: w_load_data = in_dm_read_data;
        endcase
    end

    always_comb begin
        w_wb_data = in_alu_data_out;
        case (in_writeback_data_sel)
            SEL_ALU: w_wb_data = in_alu_data_out;
            SEL_MEM: w_wb_data = w_load_data;
            SEL_PC:  w_wb_data = in_writeback_PC + XLEN'(4);
            SEL_IMM: w_wb_data = in_imm;
            default: w_wb_data = in_alu_data_out;
        endcase
    end

    logic                    valid_q,   valid_d;
    logic                    pending_q, pending_d;
    logic [REG_ADDR_W-1:0]   rd_q,      rd_d;
    logic                    we_q,      we_d;
    logic [XLEN-1:0]         data_q,    data_d;
    logic [RETIRE_CNT_W-1:0] count_q,   count_d;

    assign in_ready  = !stall;
    assign w_capture = in_valid && !stall && !flush;

    // Retirement is counted at capture so the count moves with the write strobe.
    always_comb begin
        valid_d   = valid_q;
        pending_d = 1'b0;
        rd_d      = rd_q;
        we_d      = we_q;
        data_d    = data_q;
        count_d   = count_q;
        if (w_capture) begin
            valid_d   = 1'b1;
            pending_d = 1'b1;
            rd_d      = in_rd_addr;
            we_d      = in_rd_write_en;
            data_d    = w_wb_data;
            count_d   = count_q + RETIRE_CNT_W'(1);
        end else if (!stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

    assign w_rd_live     = valid_q && we_q && (rd_q != '0);
    assign fwd_valid     = w_rd_live;
    assign rf_write_en   = w_rd_live && pending_q;
    assign rf_write_addr = rd_q;
    assign fwd_addr      = rd_q;
    assign rf_write_data = data_q;
    assign fwd_data      = data_q;
    assign retire_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Scoreboard bench for writeback_stage (XLEN=32 and XLEN=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        stall, flush;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  sel;
    logic [2:0]  f3;

    logic        valid;
    logic [31:0] alu, dm, pc, imm;
    logic [1:0]  off;
    logic        rdy32, wen32, fwv32;
    logic [4:0]  wa32, fa32;
    logic [31:0] wd32, fd32, cnt32;

    logic        valid64;
    logic [63:0] alu64, dm64, pc64, imm64;
    logic [2:0]  off64;
    logic        rdy64, wen64, fwv64;
    logic [4:0]  wa64, fa64;
    logic [63:0] wd64, fd64;
    logic [31:0] cnt64;

    writeback_stage #(.XLEN(32)) d32 (
        .clk(clk), .rst(rst), .in_valid(valid), .in_ready(rdy32),
        .stall(stall), .flush(flush), .in_rd_addr(rd), .in_rd_write_en(we),
        .in_writeback_data_sel(sel), .in_alu_data_out(alu), .in_dm_read_data(dm),
        .in_writeback_PC(pc), .in_imm(imm), .in_load_funct3(f3), .in_byte_offset(off),
        .rf_write_en(wen32), .rf_write_addr(wa32), .rf_write_data(wd32),
        .fwd_valid(fwv32), .fwd_addr(fa32), .fwd_data(fd32), .retire_count(cnt32)
    );

    writeback_stage #(.XLEN(64)) d64 (
        .clk(clk), .rst(rst), .in_valid(valid64), .in_ready(rdy64),
        .stall(stall), .flush(flush), .in_rd_addr(rd), .in_rd_write_en(we),
        .in_writeback_data_sel(sel), .in_alu_data_out(alu64), .in_dm_read_data(dm64),
        .in_writeback_PC(pc64), .in_imm(imm64), .in_load_funct3(f3), .in_byte_offset(off64),
        .rf_write_en(wen64), .rf_write_addr(wa64), .rf_write_data(wd64),
        .fwd_valid(fwv64), .fwd_addr(fa64), .fwd_data(fd64), .retire_count(cnt64)
    );

    typedef struct {
        logic        wen;
        logic        fwd;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] res;
    } stim_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_cnt   = 0;
    logic [31:0] exp_cnt64 = 0;

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; valid64 = 1'b1;
        rd = 5'd17; we = 1'b1; sel = 2'd1; f3 = 3'b010;
        alu = 32'hDEAD_BEEF; dm = 32'hCAFE_F00D; pc = 32'h1111_2222; imm = 32'h3333_4444;
        off = 2'd3; alu64 = '1; dm64 = '1; pc64 = '1; imm64 = '1; off64 = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b0) $display("FAIL reset_wen got %b want 0", wen32); else n_pass++;
        n_total++; if (fwv32 !== 1'b0) $display("FAIL reset_fwd got %b want 0", fwv32); else n_pass++;
        n_total++; if (wa32 !== 5'd0) $display("FAIL reset_addr got %0d want 0", wa32); else n_pass++;
        n_total++; if (wd32 !== 32'd0) $display("FAIL reset_data got %h want 0", wd32); else n_pass++;
        n_total++; if (cnt32 !== 32'd0) $display("FAIL reset_cnt got %0d want 0", cnt32); else n_pass++;
        n_total++; if (cnt64 !== 32'd0) $display("FAIL reset_cnt64 got %0d want 0", cnt64); else n_pass++;
        rst = 1'b0; valid = 1'b0; valid64 = 1'b0;
        exp_cnt = 0; exp_cnt64 = 0;
    endtask

    task automatic test_datapath();
        stim_t tbl[11];
        exp_t  e;
        tbl[0]  = '{5'd5,  1'b1, 2'd0, 32'h1234_5678, 32'h0,         32'h0,         32'h0,         3'b000, 2'd0, 32'h1234_5678};
        tbl[1]  = '{5'd6,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b000, 2'd3, 32'hFFFF_FF80};
        tbl[2]  = '{5'd6,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b100, 2'd3, 32'h0000_0080};
        tbl[3]  = '{5'd7,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b001, 2'd2, 32'hFFFF_80FF};
        tbl[4]  = '{5'd7,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b101, 2'd0, 32'h0000_7F01};
        tbl[5]  = '{5'd8,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b010, 2'd0, 32'h80FF_7F01};
        tbl[6]  = '{5'd8,  1'b1, 2'd1, 32'h0,         32'h80FF_7F01, 32'h0,         32'h0,         3'b000, 2'd1, 32'h0000_007F};
        tbl[7]  = '{5'd1,  1'b1, 2'd2, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         3'b000, 2'd0, 32'h0000_0000};
        tbl[8]  = '{5'd31, 1'b1, 2'd3, 32'h0,         32'h0,         32'h0,         32'hABCD_E000, 3'b000, 2'd0, 32'hABCD_E000};
        tbl[9]  = '{5'd0,  1'b1, 2'd0, 32'h0BAD_F00D, 32'h0,         32'h0,         32'h0,         3'b000, 2'd0, 32'h0BAD_F00D};
        tbl[10] = '{5'd12, 1'b0, 2'd0, 32'h0000_DEAD, 32'h0,         32'h0,         32'h0,         3'b000, 2'd0, 32'h0000_DEAD};
        for (int i = 0; i < 11; i++) begin
            valid = 1'b1; rd = tbl[i].rd; we = tbl[i].we; sel = tbl[i].sel;
            alu = tbl[i].alu; dm = tbl[i].dm; pc = tbl[i].pc; imm = tbl[i].imm;
            f3 = tbl[i].f3; off = tbl[i].off;
            exp_cnt = exp_cnt + 1;
            e.wen  = tbl[i].we && (tbl[i].rd != 5'd0);
            e.fwd  = e.wen;
            e.addr = tbl[i].rd;
            e.data = {32'h0, tbl[i].res};
            e.cnt  = exp_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_total++; if (wen32 !== e.wen) $display("FAIL dp%0d_wen got %b want %b", i, wen32, e.wen); else n_pass++;
            n_total++; if (fwv32 !== e.fwd) $display("FAIL dp%0d_fwd got %b want %b", i, fwv32, e.fwd); else n_pass++;
            if (e.wen) begin
                n_total++; if (wa32 !== e.addr) $display("FAIL dp%0d_addr got %0d want %0d", i, wa32, e.addr); else n_pass++;
            end
            n_total++; if (wd32 !== e.data[31:0]) $display("FAIL dp%0d_data got %h want %h", i, wd32, e.data[31:0]); else n_pass++;
            n_total++; if (fd32 !== e.data[31:0]) $display("FAIL dp%0d_fwd_data got %h want %h", i, fd32, e.data[31:0]); else n_pass++;
            n_total++; if (cnt32 !== e.cnt) $display("FAIL dp%0d_cnt got %0d want %0d", i, cnt32, e.cnt); else n_pass++;
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b0) $display("FAIL empty_wen got %b want 0", wen32); else n_pass++;
        n_total++; if (fwv32 !== 1'b0) $display("FAIL empty_fwd got %b want 0", fwv32); else n_pass++;
        n_total++; if (wd32 !== 32'h0000_DEAD) $display("FAIL empty_data_hold got %h want 0000dead", wd32); else n_pass++;
        n_total++; if (cnt32 !== exp_cnt) $display("FAIL empty_cnt got %0d want %0d", cnt32, exp_cnt); else n_pass++;
    endtask

    task automatic test_stall_flush();
        valid = 1'b1; rd = 5'd9; we = 1'b1; sel = 2'd0; alu = 32'h0000_0055;
        exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b1) $display("FAIL st_first_wen got %b want 1", wen32); else n_pass++;
        n_total++; if (fwv32 !== 1'b1) $display("FAIL st_first_fwd got %b want 1", fwv32); else n_pass++;
        n_total++; if (cnt32 !== exp_cnt) $display("FAIL st_first_cnt got %0d want %0d", cnt32, exp_cnt); else n_pass++;
        stall = 1'b1; rd = 5'd10; alu = 32'h0000_0066;
        #1;
        n_total++; if (rdy32 !== 1'b0) $display("FAIL st_ready got %b want 0", rdy32); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_total++; if (wen32 !== 1'b0) $display("FAIL st%0d_wen got %b want 0", i, wen32); else n_pass++;
            n_total++; if (fwv32 !== 1'b1) $display("FAIL st%0d_fwd got %b want 1", i, fwv32); else n_pass++;
            n_total++; if (fa32 !== 5'd9) $display("FAIL st%0d_faddr got %0d want 9", i, fa32); else n_pass++;
            n_total++; if (fd32 !== 32'h55) $display("FAIL st%0d_fdata got %h want 55", i, fd32); else n_pass++;
            n_total++; if (cnt32 !== exp_cnt) $display("FAIL st%0d_cnt got %0d want %0d", i, cnt32, exp_cnt); else n_pass++;
        end
        stall = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b0) $display("FAIL fl_wen got %b want 0", wen32); else n_pass++;
        n_total++; if (fwv32 !== 1'b0) $display("FAIL fl_fwd got %b want 0", fwv32); else n_pass++;
        n_total++; if (cnt32 !== exp_cnt) $display("FAIL fl_cnt got %0d want %0d", cnt32, exp_cnt); else n_pass++;
        n_total++; if (rdy32 !== 1'b1) $display("FAIL fl_ready got %b want 1", rdy32); else n_pass++;
        flush = 1'b0; valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        valid = 1'b1; rd = 5'd3; we = 1'b1; sel = 2'd0; alu = 32'h0000_0077;
        @(posedge clk);
        #1;
        valid = 1'b0; stall = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b0) $display("FAIL rms_wen got %b want 0", wen32); else n_pass++;
        n_total++; if (fwv32 !== 1'b0) $display("FAIL rms_fwd got %b want 0", fwv32); else n_pass++;
        n_total++; if (cnt32 !== 32'd0) $display("FAIL rms_cnt got %0d want 0", cnt32); else n_pass++;
        rst = 1'b0; stall = 1'b0;
        exp_cnt = 0; exp_cnt64 = 0;
        @(posedge clk);
        #1;
        n_total++; if (wen32 !== 1'b0) $display("FAIL rms_after_wen got %b want 0", wen32); else n_pass++;
    endtask

    task automatic test_xlen64();
        exp_t e;
        logic [2:0]  f3s[3]  = '{3'b010, 3'b110, 3'b011};
        logic [63:0] ress[3] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 3; i++) begin
            valid64 = 1'b1; rd = 5'd20; we = 1'b1; sel = 2'd1; f3 = f3s[i];
            dm64 = 64'h8000_0000_0000_0000; off64 = 3'd4;
            exp_cnt64 = exp_cnt64 + 1;
            e.wen = 1'b1; e.fwd = 1'b1; e.addr = 5'd20; e.data = ress[i]; e.cnt = exp_cnt64;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_total++; if (wen64 !== e.wen) $display("FAIL x64_%0d_wen got %b want %b", i, wen64, e.wen); else n_pass++;
            n_total++; if (wa64 !== e.addr) $display("FAIL x64_%0d_addr got %0d want %0d", i, wa64, e.addr); else n_pass++;
            n_total++; if (wd64 !== e.data) $display("FAIL x64_%0d_data got %h want %h", i, wd64, e.data); else n_pass++;
            n_total++; if (cnt64 !== e.cnt) $display("FAIL x64_%0d_cnt got %0d want %0d", i, cnt64, e.cnt); else n_pass++;
        end
        valid64 = 1'b1; sel = 2'd2; pc64 = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_cnt64 = exp_cnt64 + 1;
        @(posedge clk);
        #1;
        n_total++; if (wd64 !== 64'd0) $display("FAIL x64_pc_wrap got %h want 0", wd64); else n_pass++;
        n_total++; if (cnt64 !== exp_cnt64) $display("FAIL x64_pc_cnt got %0d want %0d", cnt64, exp_cnt64); else n_pass++;
        valid64 = 1'b0;
    endtask

    initial begin
        stall = 1'b0; flush = 1'b0;
        test_reset();
        test_datapath();
        test_stall_flush();
        test_reset_mid_stall();
        test_xlen64();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
